// File: rtl/location_keypad_entry.sv
// Keypad front end for the purchase block: collects two digits, validates the
// slot number and hands it to the purchase stage with a confirm pulse.
module location_keypad_entry #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int ERR_HOLD       = 16,
    parameter int MIN_LOC        = 11,
    parameter int MAX_LOC        = 68
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       process_finish,
    output logic [6:0] location,
    output logic       confirm,
    output logic       cancel,
    output logic       busy,
    output logic       entry_error,
    output logic       timeout,
    output logic [3:0] tens_digit,
    output logic [3:0] units_digit
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ONE  = 3'd1;
    localparam logic [2:0] ST_TWO  = 3'd2;
    localparam logic [2:0] ST_REQ  = 3'd3;
    localparam logic [2:0] ST_ERR  = 3'd4;

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int EW = $clog2(ERR_HOLD + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [EW-1:0] ERR_LAST = EW'(ERR_HOLD - 1);
    localparam logic [EW-1:0] ERR_ZERO = EW'(0);
    localparam logic [EW-1:0] ERR_ONE  = EW'(1);

    localparam logic [3:0] KEY_CLEAR  = 4'd10;
    localparam logic [3:0] KEY_ENTER  = 4'd11;
    localparam logic [3:0] KEY_CANCEL = 4'd12;
    localparam logic [3:0] BLANK      = 4'hF;
    localparam logic [6:0] LOC_MIN    = 7'(MIN_LOC);
    localparam logic [6:0] LOC_MAX    = 7'(MAX_LOC);

    // Two BCD digits to a slot number; 9*10+9 still fits in 7 bits.
    function automatic logic [6:0] loc_value(input logic [3:0] t, input logic [3:0] u);
        return ({3'b000, t} * 7'd10) + {3'b000, u};
    endfunction

    logic [2:0]    state_r, state_nx_s;
    logic [CW-1:0] cnt_r, cnt_nx_s;
    logic [EW-1:0] err_cnt_r, err_cnt_nx_s;
    logic [6:0]    location_r, location_nx_s;
    logic          confirm_r, confirm_nx_s;
    logic          cancel_r, cancel_nx_s;
    logic          busy_r, busy_nx_s;
    logic          entry_error_r, entry_error_nx_s;
    logic          timeout_r, timeout_nx_s;
    logic [3:0]    tens_r, tens_nx_s;
    logic [3:0]    units_r, units_nx_s;

    logic          is_digit_s, is_clear_s, is_enter_s, is_cancel_s;
    logic          go_err_s;
    logic [6:0]    entry_val_s;

    assign is_digit_s  = key_valid && (key_code <= 4'd9);
    assign is_clear_s  = key_valid && (key_code == KEY_CLEAR);
    assign is_enter_s  = key_valid && (key_code == KEY_ENTER);
    assign is_cancel_s = key_valid && (key_code == KEY_CANCEL);
    assign entry_val_s = loc_value(tens_r, units_r);

    // Next-state and next-output logic for the entry sequencer.
    always_comb begin
        state_nx_s       = state_r;
        cnt_nx_s         = cnt_r;
        err_cnt_nx_s     = err_cnt_r;
        location_nx_s    = location_r;
        confirm_nx_s     = 1'b0;
        cancel_nx_s      = 1'b0;
        busy_nx_s        = busy_r;
        entry_error_nx_s = entry_error_r;
        timeout_nx_s     = 1'b0;
        tens_nx_s        = tens_r;
        units_nx_s       = units_r;
        go_err_s         = 1'b0;

        case (state_r)
            ST_IDLE: begin
                cnt_nx_s = CNT_ZERO;
                if (is_digit_s) begin
                    tens_nx_s  = key_code;
                    state_nx_s = ST_ONE;
                end else if (is_cancel_s) begin
                    cancel_nx_s = 1'b1;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ONE, ST_TWO: begin
                cnt_nx_s = CNT_ZERO;
                if (is_digit_s && (state_r == ST_ONE)) begin
                    units_nx_s = key_code;
                    state_nx_s = ST_TWO;
                end else if (is_clear_s) begin
                    if (state_r == ST_ONE) begin
                        tens_nx_s  = BLANK;
                        state_nx_s = ST_IDLE;
                    end else begin
                        units_nx_s = BLANK;
                        state_nx_s = ST_ONE;
                    end
                end else if (is_cancel_s) begin
                    cancel_nx_s = 1'b1;
                    tens_nx_s   = BLANK;
                    units_nx_s  = BLANK;
                    state_nx_s  = ST_IDLE;
                end else if (is_enter_s) begin
                    if ((state_r == ST_TWO) && (entry_val_s >= LOC_MIN) && (entry_val_s <= LOC_MAX)) begin
                        location_nx_s = entry_val_s;
                        confirm_nx_s  = 1'b1;
                        busy_nx_s     = 1'b1;
                        state_nx_s    = ST_REQ;
                    end else begin
                        go_err_s = 1'b1;
                    end
                end else if (cnt_r == CNT_LAST) begin
                    // A key arriving on the expiry cycle is handled above and wins.
                    timeout_nx_s = 1'b1;
                    tens_nx_s    = BLANK;
                    units_nx_s   = BLANK;
                    state_nx_s   = ST_IDLE;
                end else begin
                    cnt_nx_s = cnt_r + CNT_ONE;
                end
            end
            ST_REQ: begin
                cnt_nx_s = CNT_ZERO;
                if (process_finish) begin
                    busy_nx_s  = 1'b0;
                    tens_nx_s  = BLANK;
                    units_nx_s = BLANK;
                    state_nx_s = ST_IDLE;
                end else if (is_cancel_s) begin
                    cancel_nx_s = 1'b1;
                end else if (cnt_r == CNT_LAST) begin
                    busy_nx_s = 1'b0;
                    go_err_s  = 1'b1;
                end else begin
                    cnt_nx_s = cnt_r + CNT_ONE;
                end
            end
            ST_ERR: begin
                cnt_nx_s = CNT_ZERO;
                if (err_cnt_r == ERR_LAST) begin
                    entry_error_nx_s = 1'b0;
                    err_cnt_nx_s     = ERR_ZERO;
                    state_nx_s       = ST_IDLE;
                end else begin
                    err_cnt_nx_s = err_cnt_r + ERR_ONE;
                end
            end
            default: begin
                state_nx_s       = ST_IDLE;
                cnt_nx_s         = CNT_ZERO;
                err_cnt_nx_s     = ERR_ZERO;
                busy_nx_s        = 1'b0;
                entry_error_nx_s = 1'b0;
                tens_nx_s        = BLANK;
                units_nx_s       = BLANK;
            end
        endcase

        if (go_err_s) begin
            state_nx_s       = ST_ERR;
            err_cnt_nx_s     = ERR_ZERO;
            entry_error_nx_s = 1'b1;
            tens_nx_s        = BLANK;
            units_nx_s       = BLANK;
            cnt_nx_s         = CNT_ZERO;
        end else begin
            err_cnt_nx_s = err_cnt_nx_s;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            cnt_r         <= CNT_ZERO;
            err_cnt_r     <= ERR_ZERO;
            location_r    <= 7'd0;
            confirm_r     <= 1'b0;
            cancel_r      <= 1'b0;
            busy_r        <= 1'b0;
            entry_error_r <= 1'b0;
            timeout_r     <= 1'b0;
            tens_r        <= BLANK;
            units_r       <= BLANK;
        end else begin
            state_r       <= state_nx_s;
            cnt_r         <= cnt_nx_s;
            err_cnt_r     <= err_cnt_nx_s;
            location_r    <= location_nx_s;
            confirm_r     <= confirm_nx_s;
            cancel_r      <= cancel_nx_s;
            busy_r        <= busy_nx_s;
            entry_error_r <= entry_error_nx_s;
            timeout_r     <= timeout_nx_s;
            tens_r        <= tens_nx_s;
            units_r       <= units_nx_s;
        end
    end

    assign location    = location_r;
    assign confirm     = confirm_r;
    assign cancel      = cancel_r;
    assign busy        = busy_r;
    assign entry_error = entry_error_r;
    assign timeout     = timeout_r;
    assign tens_digit  = tens_r;
    assign units_digit = units_r;

endmodule

// File: tb/tb_location_keypad_entry.sv
// Scoreboard bench for location_keypad_entry: directed key sequences push the
// expected front-panel events, a forked monitor pops and compares them.
module tb_location_keypad_entry;

    localparam int K_CONF  = 1;
    localparam int K_CANC  = 2;
    localparam int K_TMO   = 3;
    localparam int K_BFALL = 4;
    localparam int K_ERRD  = 5;

    localparam logic [3:0] KCLR = 4'd10;
    localparam logic [3:0] KENT = 4'd11;
    localparam logic [3:0] KCAN = 4'd12;
    localparam logic [3:0] BL   = 4'hF;

    typedef struct {
        int         kind;
        int         a;
        int         b;
        logic [3:0] t;
        logic [3:0] u;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_valid;
    logic [3:0] key_code;
    logic       process_finish;
    logic [6:0] location;
    logic       confirm, cancel, busy, entry_error, timeout;
    logic [3:0] tens_digit, units_digit;

    ev_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  cyc = 0;
    int  key_cyc = 0;
    int  pf_cyc = 0;
    logic rst_edge = 1'b1;

    location_keypad_entry #(
        .TIMEOUT_CYCLES(20),
        .ERR_HOLD(16),
        .MIN_LOC(11),
        .MAX_LOC(68)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .key_valid(key_valid),
        .key_code(key_code),
        .process_finish(process_finish),
        .location(location),
        .confirm(confirm),
        .cancel(cancel),
        .busy(busy),
        .entry_error(entry_error),
        .timeout(timeout),
        .tens_digit(tens_digit),
        .units_digit(units_digit)
    );

    always #5 clk = ~clk;

    // Cycle bookkeeping used to measure latencies from the last sampled key.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (key_valid) key_cyc <= cyc + 1;
        if (process_finish) pf_cyc <= cyc + 1;
        rst_edge <= !rst_n;
    end

    task automatic push(input int kind, input int a, input int b, input logic [3:0] t, input logic [3:0] u);
        ev_t e;
        e.kind = kind; e.a = a; e.b = b; e.t = t; e.u = u;
        exp_q.push_back(e);
    endtask

    task automatic check_ev(input ev_t got);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind=%0d a=%0d b=%0d t=%h u=%h, expected none",
                     got.kind, got.a, got.b, got.t, got.u);
        end else begin
            e = exp_q.pop_front();
            if (got.kind != e.kind || got.a != e.a || got.b != e.b || got.t != e.t || got.u != e.u) begin
                errors++;
                $display("FAIL event: got kind=%0d a=%0d b=%0d t=%h u=%h, expected kind=%0d a=%0d b=%0d t=%h u=%h",
                         got.kind, got.a, got.b, got.t, got.u, e.kind, e.a, e.b, e.t, e.u);
            end
        end
    endtask

    task automatic chk(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, expv);
        end
    endtask

    task automatic press(input logic [3:0] k);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic finish_pulse();
        @(negedge clk);
        process_finish = 1'b1;
        @(negedge clk);
        process_finish = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_loc"}, int'(location), 0);
        chk({tag, "_flags"}, int'({confirm, cancel, busy, entry_error, timeout}), 0);
        chk({tag, "_digits"}, int'({tens_digit, units_digit}), 255);
    endtask

    initial begin
        rst_n          = 1'b0;
        key_valid      = 1'b0;
        key_code       = 4'd0;
        process_finish = 1'b0;

        fork
            begin : monitor
                ev_t  g;
                int   conf_cyc = 0;
                int   err_len = 0;
                logic prev_busy = 1'b0;
                logic prev_err = 1'b0;
                forever begin
                    @(negedge clk);
                    if (!rst_edge) begin
                        if (confirm) begin
                            conf_cyc = cyc;
                            g.kind = K_CONF; g.a = int'(location); g.b = int'(busy);
                            g.t = tens_digit; g.u = units_digit;
                            check_ev(g);
                        end
                        if (cancel) begin
                            g.kind = K_CANC; g.a = int'(location); g.b = int'(busy);
                            g.t = tens_digit; g.u = units_digit;
                            check_ev(g);
                        end
                        if (timeout) begin
                            g.kind = K_TMO; g.a = cyc - key_cyc; g.b = int'(busy);
                            g.t = tens_digit; g.u = units_digit;
                            check_ev(g);
                        end
                        if (prev_busy && !busy) begin
                            g.kind = K_BFALL; g.a = int'(entry_error);
                            g.b = entry_error ? (cyc - conf_cyc) : (cyc - pf_cyc);
                            g.t = tens_digit; g.u = units_digit;
                            check_ev(g);
                        end
                        if (entry_error) begin
                            err_len++;
                        end else if (prev_err) begin
                            g.kind = K_ERRD; g.a = err_len; g.b = int'(location);
                            g.t = tens_digit; g.u = units_digit;
                            check_ev(g);
                            err_len = 0;
                        end
                    end else begin
                        err_len = 0;
                    end
                    prev_busy = busy;
                    prev_err  = entry_error;
                end
            end
        join_none

        idle(3);
        check_reset_values("reset");
        rst_n = 1'b1;

        // 42: confirm then finish
        push(K_CONF, 42, 1, 4'd4, 4'd2);
        press(4'd4); press(4'd2); press(KENT);
        idle(3);
        push(K_BFALL, 0, 0, BL, BL);
        finish_pulse();
        idle(2);

        // Lower and upper boundaries
        push(K_CONF, 11, 1, 4'd1, 4'd1);
        press(4'd1); press(4'd1); press(KENT);
        idle(2);
        push(K_BFALL, 0, 0, BL, BL);
        finish_pulse();
        push(K_CONF, 68, 1, 4'd6, 4'd8);
        press(4'd6); press(4'd8); press(KENT);
        idle(2);
        push(K_BFALL, 0, 0, BL, BL);
        finish_pulse();

        // Out of range both sides; a key during the error hold is dropped
        push(K_ERRD, 16, 68, BL, BL);
        press(4'd6); press(4'd9); press(KENT);
        press(4'd5);
        idle(20);
        push(K_ERRD, 16, 68, BL, BL);
        press(4'd0); press(4'd5); press(KENT);
        idle(20);

        // Editing with CLEAR and an ignored third digit
        push(K_CONF, 25, 1, 4'd2, 4'd5);
        press(4'd7); press(4'd3); press(KCLR); press(KCLR);
        press(4'd2); press(4'd5); press(4'd9); press(KENT);
        idle(2);
        push(K_BFALL, 0, 0, BL, BL);
        finish_pulse();

        // Incomplete entry
        push(K_ERRD, 16, 25, BL, BL);
        press(4'd3); press(KENT);
        idle(20);

        // Partial-entry inactivity timeout
        push(K_TMO, 20, 0, BL, BL);
        press(4'd3);
        idle(25);

        // Key on the expiry cycle wins over the timeout
        press(4'd4);
        idle(18);
        press(4'd5);
        push(K_CONF, 45, 1, 4'd4, 4'd5);
        press(KENT);
        idle(2);
        push(K_BFALL, 0, 0, BL, BL);
        finish_pulse();

        // Purchase never acknowledged
        push(K_CONF, 57, 1, 4'd5, 4'd7);
        push(K_BFALL, 1, 20, BL, BL);
        push(K_ERRD, 16, 57, BL, BL);
        press(4'd5); press(4'd7); press(KENT);
        idle(45);

        // Cancel in TWO and in IDLE
        push(K_CANC, 57, 0, BL, BL);
        press(4'd2); press(4'd4); press(KCAN);
        push(K_CANC, 57, 0, BL, BL);
        press(KCAN);
        idle(2);

        // Cancel while waiting, then reset mid-transaction
        push(K_CONF, 33, 1, 4'd3, 4'd3);
        press(4'd3); press(4'd3); press(KENT);
        push(K_CANC, 33, 1, 4'd3, 4'd3);
        press(KCAN);
        idle(2);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_values("midreq_reset");
        rst_n = 1'b1;
        idle(30);
        check_reset_values("post_reset");

        idle(3);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_events: got %0d left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/location_keypad_entry.md
Name: location_keypad_entry

Overview:
- Upstream stage of the user purchase-processing block. Converts single-cycle keypad events into a validated two-digit slot location (11..68).
- Issues a one-cycle confirm or cancel pulse to the purchase stage, then holds the location until that stage reports process_finish.
- Provides digit display outputs plus error and timeout flags for the front panel.

Parameters:
- TIMEOUT_CYCLES, 1000, inactivity limit in cycles for partial entry and for waiting on process_finish.
- ERR_HOLD, 16, number of cycles entry_error stays high.
- MIN_LOC, 11, lowest valid location.
- MAX_LOC, 68, highest valid location.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- key_valid  input  1  one-cycle strobe; key_code valid this cycle.
- key_code  input  4  0-9 digit; 10 CLEAR; 11 ENTER; 12 CANCEL; 13-15 ignored.
- process_finish  input  1  from purchase stage; transaction done.
- location  output  7  latched slot number; held while busy.
- confirm  output  1  one-cycle pulse; request purchase of location.
- cancel  output  1  one-cycle pulse; user abort.
- busy  output  1  high while waiting for process_finish.
- entry_error  output  1  invalid entry or purchase not acknowledged.
- timeout  output  1  one-cycle pulse on partial-entry inactivity timeout.
- tens_digit  output  4  display tens digit; 4'hF = blank.
- units_digit  output  4  display units digit; 4'hF = blank.

Behaviour:
- Reset (rst_n=0 at a clk edge, wins over everything, including mid-transaction):
  - State goes to IDLE.
  - location=0; confirm, cancel, busy, entry_error, timeout = 0.
  - tens_digit = units_digit = 4'hF.
  - Inactivity counter = 0.
- All outputs are registered; every response appears at the edge after the key is sampled.
- States: IDLE, ONE, TWO, REQ, ERR.
- IDLE:
  - Digit d: tens=d, go to ONE.
  - CANCEL: cancel pulse, stay in IDLE.
  - CLEAR/ENTER: ignored.
- ONE:
  - Digit d: units=d, go to TWO.
  - CLEAR: blank tens, go to IDLE.
  - ENTER: go to ERR (incomplete entry).
  - CANCEL: cancel pulse, blank both digits, go to IDLE.
- TWO:
  - Further digits: ignored.
  - CLEAR: blank units, go to ONE.
  - CANCEL: as in ONE.
  - ENTER: compute v = tens*10 + units in 7-bit unsigned arithmetic (max 99, no overflow).
    - If MIN_LOC <= v <= MAX_LOC: location=v, confirm=1 for exactly one cycle, busy=1, go to REQ.
    - Else: go to ERR, location unchanged.
- REQ:
  - All keys ignored except CANCEL, which pulses cancel but stays in REQ.
  - On process_finish=1: busy=0, digits blanked, go to IDLE on the next edge. process_finish wins over a same-cycle key; that key is dropped.
  - If TIMEOUT_CYCLES elapse without process_finish (e.g. insufficient balance): busy=0, go to ERR.
- ERR:
  - entry_error=1 for exactly ERR_HOLD cycles, then 0.
  - Digits are blanked on entry; all keys are ignored.
  - Returns to IDLE afterwards.
- Inactivity counter:
  - Counts in ONE, TWO and REQ.
  - Cleared on every accepted key and on every state change.
  - In ONE/TWO, reaching TIMEOUT_CYCLES: timeout pulse, digits blanked, go to IDLE.
  - A key in the same cycle as expiry wins: key processed, counter cleared.
- confirm never asserts on consecutive cycles; at most one confirm per REQ entry.
- location retains its last value after returning to IDLE; only a new valid ENTER changes it.

Test Plan:
- Keys 4,2,ENTER (process_finish=0):
  - Edge after ENTER: location=42, confirm high exactly 1 cycle, busy=1.
  - Then pulse process_finish: next edge busy=0, tens/units=F, state IDLE.
- Boundaries:
  - 1,1,ENTER → location=11 with confirm.
  - 6,8,ENTER → location=68 with confirm.
  - 6,9,ENTER and 0,5,ENTER → entry_error high for 16 cycles, no confirm, location still 68.
- Editing:
  - 7,3,CLEAR,CLEAR,2,5,ENTER → location=25.
  - 3,ENTER → ERR (entry_error 16 cycles).
  - A third digit in TWO leaves the display unchanged.
- Timeouts (TIMEOUT_CYCLES=20):
  - Key 3 then no activity → timeout pulse 20 cycles later, digits blanked.
  - Valid entry with no process_finish → busy falls after 20 cycles and entry_error rises.
- Cancel and reset:
  - CANCEL in TWO → cancel pulse 1 cycle, IDLE.
  - rst_n=0 mid-REQ → next edge all outputs at reset values; confirm not reissued after rst_n returns high.
